step_sequencer: RTL and testbench

Controller end of the signed step-count register interface. Accepts a move command (signed step count, inter-step delay), loads the count into the step-count register, and watches that register's negative/positive/zero flags. For each remaining step it drives one increment or decrement and advances the stepper coil pattern, until the register reads zero. Sits between the instruction decode path and the motor driver pins.

---
 rtl/stepper_pkg.sv | 28 ++
 rtl/step_phase_gen.sv | 53 +++++
 rtl/step_sequencer.sv | 147 ++++++++++++++
 tb/tb_step_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Shared types and constants for the step sequencer and its coil phase generator.
// Half-step coil table is selected in step_phase_gen by STEP_SEQ_HALF_STEP_EN.
package stepper_pkg;

  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_DELAY_W   = 16;
  localparam int unsigned SETTLE_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    CHECK,
    STEP,
    WAIT
  } state_t;

  // Coil drive patterns {A,B,C,D}, indexed by phase.
  localparam logic [3:0] FULL_STEP_TABLE [0:3] = '{
    4'b1100, 4'b0110, 4'b0011, 4'b1001
  };

  localparam logic [3:0] HALF_STEP_TABLE [0:7] = '{
    4'b1000, 4'b1100, 4'b0100, 4'b0110,
    4'b0010, 4'b0011, 4'b0001, 4'b1001
  };

endpackage

// File: rtl/step_phase_gen.sv
// Stepper phase index and registered coil drive; STEP_SEQ_HALF_STEP_EN selects
// the 8-entry half-step table, otherwise the 4-entry full-step table is used.
module step_phase_gen
  import stepper_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       energize,
  input  logic       advance,
  input  logic       retreat,
  output logic [3:0] coil
);

`ifdef STEP_SEQ_HALF_STEP_EN
  localparam int unsigned PHASE_W = 3;
`else
  localparam int unsigned PHASE_W = 2;
`endif

  logic [PHASE_W-1:0] idx;
  logic [PHASE_W-1:0] idx_next;

  function automatic logic [3:0] pattern(input logic [PHASE_W-1:0] i);
`ifdef STEP_SEQ_HALF_STEP_EN
    return HALF_STEP_TABLE[i];
`else
    return FULL_STEP_TABLE[i];
`endif
  endfunction

  // Index wraps naturally at the table length in both directions.
  always_comb begin
    idx_next = idx;
    if (advance) begin
      idx_next = idx + PHASE_W'(1);
    end else if (retreat) begin
      idx_next = idx - PHASE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx  <= '0;
      coil <= 4'b0000;
    end else if (advance || retreat) begin
      idx  <= idx_next;
      coil <= pattern(idx_next);
    end else if (energize) begin
      coil <= pattern(idx);
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// Move-command sequencer driving a signed step-count register and stepper coils.
// Build with STEP_SEQ_HALF_STEP_EN for half-step coil sequencing.
module step_sequencer
  import stepper_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned DELAY_W = DEF_DELAY_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [DATA_W-1:0]  cmd_steps,
  input  logic [DELAY_W-1:0] cmd_delay,
  input  logic               abort,
  output logic               reg_load,
  output logic               reg_increment,
  output logic               reg_decrement,
  output logic [DATA_W-1:0]  reg_data,
  input  logic               negative,
  input  logic               positive,
  input  logic               zero,
  output logic [3:0]         coil,
  output logic               busy,
  output logic               done
);

  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES);

  state_t               state;
  logic [DELAY_W-1:0]   delay_q;
  logic [DELAY_W-1:0]   delay_cnt;
  logic [SETTLE_W-1:0]  settle_cnt;
  logic                 stepped;

  logic fwd_c;
  logic rev_c;
  logic accept_c;
  logic advance_c;
  logic retreat_c;

  assign cmd_ready = (state == IDLE);

  // Exactly one flag set selects a direction; anything else reads as zero.
  always_comb begin
    fwd_c     = positive && !negative && !zero;
    rev_c     = negative && !positive && !zero;
    accept_c  = (state == IDLE) && cmd_valid;
    advance_c = (state == CHECK) && !abort && fwd_c;
    retreat_c = (state == CHECK) && !abort && rev_c;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      reg_load      <= 1'b0;
      reg_increment <= 1'b0;
      reg_decrement <= 1'b0;
      reg_data      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      delay_q       <= '0;
      delay_cnt     <= '0;
      settle_cnt    <= '0;
      stepped       <= 1'b0;
    end else begin
      reg_load      <= 1'b0;
      reg_increment <= 1'b0;
      reg_decrement <= 1'b0;
      done          <= 1'b0;
      // Abort pre-empts every active state, including a CHECK about to strobe.
      if (state != IDLE && abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_valid) begin
              state    <= LOAD;
              reg_data <= cmd_steps;
              delay_q  <= cmd_delay;
              reg_load <= 1'b1;
              busy     <= 1'b1;
            end
          end
          LOAD: begin
            state      <= SETTLE;
            settle_cnt <= SETTLE_W'(SETTLE_CYCLES - 1);
            stepped    <= 1'b0;
          end
          SETTLE: begin
            if (settle_cnt == '0) begin
              if (stepped && delay_q != '0) begin
                state     <= WAIT;
                delay_cnt <= delay_q - DELAY_W'(1);
              end else begin
                state <= CHECK;
              end
            end else begin
              settle_cnt <= settle_cnt - SETTLE_W'(1);
            end
          end
          CHECK: begin
            if (fwd_c) begin
              state         <= STEP;
              reg_decrement <= 1'b1;
            end else if (rev_c) begin
              state         <= STEP;
              reg_increment <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          STEP: begin
            state      <= SETTLE;
            settle_cnt <= SETTLE_W'(SETTLE_CYCLES - 1);
            stepped    <= 1'b1;
          end
          WAIT: begin
            if (delay_cnt == '0) begin
              state <= CHECK;
            end else begin
              delay_cnt <= delay_cnt - DELAY_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  step_phase_gen u_phase (
    .clk      (clk),
    .reset_n  (reset_n),
    .energize (accept_c),
    .advance  (advance_c),
    .retreat  (retreat_c),
    .coil     (coil)
  );

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer with a behavioural step-count register
// whose flags lag its contents by one cycle.
module tb_step_sequencer;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_steps;
  logic [15:0] cmd_delay;
  logic        abort;
  logic        reg_load;
  logic        reg_increment;
  logic        reg_decrement;
  logic [7:0]  reg_data;
  logic        negative;
  logic        positive;
  logic        zero;
  logic [3:0]  coil;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int acc      = 0;

  int         load_t[$];
  int         load_d[$];
  int         load_c[$];
  int         inc_t[$];
  int         dec_t[$];
  int         step_c[$];
  int         done_t[$];

  logic [3:0] tbl [8];
  int         n_ph;

  step_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_steps     (cmd_steps),
    .cmd_delay     (cmd_delay),
    .abort         (abort),
    .reg_load      (reg_load),
    .reg_increment (reg_increment),
    .reg_decrement (reg_decrement),
    .reg_data      (reg_data),
    .negative      (negative),
    .positive      (positive),
    .zero          (zero),
    .coil          (coil),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Step-count register model: flags reflect the previous cycle's contents.
  logic signed [7:0] rcnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rcnt     <= 8'sd0;
      zero     <= 1'b1;
      positive <= 1'b0;
      negative <= 1'b0;
    end else begin
      if (reg_load)           rcnt <= reg_data;
      else if (reg_increment) rcnt <= rcnt + 8'sd1;
      else if (reg_decrement) rcnt <= rcnt - 8'sd1;
      zero     <= (rcnt == 8'sd0);
      positive <= (rcnt > 8'sd0);
      negative <= (rcnt < 8'sd0);
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (reg_load) begin
        load_t.push_back(cyc);
        load_d.push_back(int'(reg_data));
        load_c.push_back(int'(coil));
      end
      if (reg_increment) begin
        inc_t.push_back(cyc);
        step_c.push_back(int'(coil));
      end
      if (reg_decrement) begin
        dec_t.push_back(cyc);
        step_c.push_back(int'(coil));
      end
      if (done) done_t.push_back(cyc);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    load_t.delete(); load_d.delete(); load_c.delete();
    inc_t.delete();  dec_t.delete();  step_c.delete(); done_t.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    clear_logs();
  endtask

  // Issues a command in IDLE; acc is the cycle index of the LOAD cycle (rel 1).
  task automatic issue(input int steps, input int dly, input logic ab);
    cmd_steps = 8'(steps);
    cmd_delay = 16'(dly);
    cmd_valid = 1'b1;
    abort     = ab;
    tick();
    cmd_valid = 1'b0;
    abort     = 1'b0;
    acc       = cyc;
  endtask

  task automatic run_move(input string name, input int steps, input int dly,
                          input logic ab, input int exp_done);
    int         n;
    int         per;
    int         ph;
    logic [7:0] exp_d;
    n     = (steps < 0) ? -steps : steps;
    per   = 4 + dly;
    exp_d = 8'(steps);
    do_reset();
    issue(steps, dly, ab);
    for (int i = 0; i < exp_done + 20 && done_t.size() == 0; i++) tick();
    if (done_t.size() == 0) check({name, "_done_timeout"}, 0, 1);
    repeat (6) tick();
    check({name, "_load_cnt"}, load_t.size(), 1);
    if (load_t.size() > 0) begin
      check({name, "_load_rel"}, load_t[0] - acc + 1, 1);
      check({name, "_load_data"}, load_d[0], int'(exp_d));
      check({name, "_load_coil"}, load_c[0], int'(tbl[0]));
    end
    check({name, "_dec_cnt"}, dec_t.size(), (steps > 0) ? n : 0);
    check({name, "_inc_cnt"}, inc_t.size(), (steps < 0) ? n : 0);
    for (int k = 0; k < n; k++) begin
      if (steps > 0 && k < dec_t.size())
        check({name, "_dec_rel"}, dec_t[k] - acc + 1, 5 + k * per);
      if (steps < 0 && k < inc_t.size())
        check({name, "_inc_rel"}, inc_t[k] - acc + 1, 5 + k * per);
      ph = (steps > 0) ? ((k + 1) % n_ph) : ((n_ph - ((k + 1) % n_ph)) % n_ph);
      if (k < step_c.size()) check({name, "_step_coil"}, step_c[k], int'(tbl[ph]));
    end
    check({name, "_done_cnt"}, done_t.size(), 1);
    if (done_t.size() > 0) check({name, "_done_rel"}, done_t[0] - acc + 1, exp_done);
    check({name, "_busy_end"}, int'(busy), 0);
    check({name, "_ready_end"}, int'(cmd_ready), 1);
  endtask

  initial begin
`ifdef STEP_SEQ_HALF_STEP_EN
    tbl  = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
    n_ph = 8;
`else
    tbl  = '{4'b1100, 4'b0110, 4'b0011, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    n_ph = 4;
`endif
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_steps = 8'd0;
    cmd_delay = 16'd0;
    abort     = 1'b0;
    repeat (2) tick();
    check("rst_coil", int'(coil), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_strobes", int'({reg_load, reg_increment, reg_decrement}), 0);
    check("rst_data", int'(reg_data), 0);
    reset_n = 1'b1;
    tick();
    check("rst_ready", int'(cmd_ready), 1);

    // Abort alongside the command in IDLE is ignored; the command is accepted.
    run_move("fwd3",  3,    0, 1'b0, 17);
    run_move("rev2",  -2,   5, 1'b0, 23);
    run_move("zero",  0,    0, 1'b1, 5);
    run_move("fwd9",  9,    0, 1'b0, 41);
    run_move("min",   -128, 0, 1'b0, 517);

    // Abort in the third WAIT; a command offered mid-move must be dropped.
    do_reset();
    issue(10, 2, 1'b0);
    while (cyc < acc + 9) tick();
    cmd_steps = 8'd7;
    cmd_valid = 1'b1;
    check("abort_ready_busy", int'(cmd_ready), 0);
    tick();
    cmd_valid = 1'b0;
    while (cyc < acc + 19) tick();
    check("abort_dec_before", dec_t.size(), 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_done_now", int'(done), 1);
    check("abort_busy_now", int'(busy), 0);
    repeat (10) tick();
    check("abort_dec_cnt", dec_t.size(), 3);
    check("abort_load_cnt", load_t.size(), 1);
    check("abort_done_cnt", done_t.size(), 1);
    if (done_t.size() > 0) check("abort_done_rel", done_t[0] - acc + 1, 21);
    check("abort_coil", int'(coil), int'(tbl[3]));
    check("abort_ready_end", int'(cmd_ready), 1);

    // Asynchronous reset during a STEP cycle.
    do_reset();
    issue(5, 0, 1'b0);
    while (cyc < acc + 8) tick();
    check("rstmid_dec_pre", int'(reg_decrement), 1);
    reset_n = 1'b0;
    #1;
    check("rstmid_coil", int'(coil), 0);
    check("rstmid_strobes", int'({reg_load, reg_increment, reg_decrement}), 0);
    check("rstmid_busy", int'(busy), 0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check("rstmid_ready", int'(cmd_ready), 1);
    check("rstmid_coil_after", int'(coil), 0);
    check("rstmid_done_after", int'(done), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
